// File: rtl/mips_main.sv
// Single-cycle MIPS-subset datapath running a fixed 3x3 matrix-multiply program from ROM.
// Define DOUT_REG_EN to register the d* outputs (one-clock lag) instead of tracking dmem combinationally.
module mips_main #(
  parameter int IMEM_WORDS = 128,
  parameter int DMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] d11, d12, d13,
  output logic [31:0] d21, d22, d23,
  output logic [31:0] d31, d32, d33
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  function automatic logic [31:0] r_type(logic [5:0] op, int rs, int rt, int rd, logic [5:0] fn);
    return {op, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Loads A->$1..$9, B->$10..$18; each C element uses fresh destinations so any
  // instruction can be re-executed without accumulating.
  function automatic logic [31:0] rom_word(int idx);
    int k, s, r, c;
    if (idx < 18) return i_type(6'h23, 0, idx + 1, idx * 4);
    if (idx >= 72) return 32'h0;
    k = (idx - 18) / 6;
    s = (idx - 18) % 6;
    r = k / 3;
    c = k % 3;
    case (s)
      0:       return r_type(6'h1C, 1 + 3 * r, 10 + c, 19, 6'h02);
      1:       return r_type(6'h1C, 2 + 3 * r, 13 + c, 20, 6'h02);
      2:       return r_type(6'h1C, 3 + 3 * r, 16 + c, 21, 6'h02);
      3:       return r_type(6'h00, 19, 20, 22, 6'h20);
      4:       return r_type(6'h00, 22, 21, 23, 6'h20);
      default: return i_type(6'h2B, 0, 23, (18 + k) * 4);
    endcase
  endfunction

  function automatic logic [31:0] dmem_init(int i);
    if (i < 9)  return 32'(i + 1);
    if (i < 18) return 32'(18 - i);
    return 32'h0;
  endfunction

  logic [31:0] rom_w [IMEM_WORDS];
  generate
    for (genvar gi = 0; gi < IMEM_WORDS; gi++) begin : g_rom
      assign rom_w[gi] = rom_word(gi);
    end
  endgenerate

  logic [31:0] rf_q   [32];
  logic [31:0] dmem_q [DMEM_WORDS];

  logic [31:0] instr;
  logic        fetch_ok;
  // Misaligned or out-of-ROM addresses fetch a NOP.
  assign fetch_ok = (pc[31:2] < 30'(IMEM_WORDS)) && (pc[1:0] == 2'b00);
  assign instr    = fetch_ok ? rom_w[pc[IAW+1:2]] : 32'h0;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm, rs_val, rt_val, mem_addr, load_data;
  logic [DAW-1:0] mem_idx;
  logic        mem_ok;

  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign simm     = {{16{instr[15]}}, instr[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rt_val   = (rt == 5'd0) ? 32'h0 : rf_q[rt];
  assign mem_addr = rs_val + simm;
  assign mem_ok   = mem_addr[31:2] < 30'(DMEM_WORDS);
  assign mem_idx  = mem_addr[DAW+1:2];
  assign load_data = mem_ok ? dmem_q[mem_idx] : 32'h0;

  logic unused_bits;
  assign unused_bits = ^{instr[10:6], mem_addr[1:0]};

  logic        rf_we_d, mem_we_d;
  logic [4:0]  rf_waddr_d;
  logic [31:0] rf_wdata_d;

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = 5'd0;
    rf_wdata_d = 32'h0;
    mem_we_d   = 1'b0;
    case (op)
      6'h00: begin
        if (funct == 6'h20) begin
          rf_we_d = 1'b1; rf_waddr_d = rd; rf_wdata_d = rs_val + rt_val;
        end else if (funct == 6'h22) begin
          rf_we_d = 1'b1; rf_waddr_d = rd; rf_wdata_d = rs_val - rt_val;
        end
      end
      6'h1C: begin
        if (funct == 6'h02) begin
          rf_we_d = 1'b1; rf_waddr_d = rd; rf_wdata_d = rs_val * rt_val;
        end
      end
      6'h08: begin rf_we_d = 1'b1; rf_waddr_d = rt; rf_wdata_d = rs_val + simm; end
      6'h23: begin rf_we_d = 1'b1; rf_waddr_d = rt; rf_wdata_d = load_data; end
      6'h2B: mem_we_d = mem_ok;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else if (rf_we_d && rf_waddr_d != 5'd0) begin
      rf_q[rf_waddr_d] <= rf_wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= dmem_init(i);
    end else if (mem_we_d) begin
      dmem_q[mem_idx] <= rt_val;
    end
  end

`ifdef DOUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {d11, d12, d13, d21, d22, d23, d31, d32, d33} <= '0;
    end else begin
      d11 <= dmem_q[18]; d12 <= dmem_q[19]; d13 <= dmem_q[20];
      d21 <= dmem_q[21]; d22 <= dmem_q[22]; d23 <= dmem_q[23];
      d31 <= dmem_q[24]; d32 <= dmem_q[25]; d33 <= dmem_q[26];
    end
  end
`else
  assign d11 = dmem_q[18]; assign d12 = dmem_q[19]; assign d13 = dmem_q[20];
  assign d21 = dmem_q[21]; assign d22 = dmem_q[22]; assign d23 = dmem_q[23];
  assign d31 = dmem_q[24]; assign d32 = dmem_q[25]; assign d33 = dmem_q[26];
`endif

endmodule

// File: tb/tb_mips_main.sv
// Directed bench for mips_main: reset, full program run, hold, mid-run reset,
// single-instruction hold and forced-instruction checks against hand-computed C.
module tb_mips_main;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = 32'hFFFF_FFFC;
  logic [31:0] d11, d12, d13, d21, d22, d23, d31, d32, d33;

  int n_checks = 0;
  int n_fail   = 0;

  // C = A*B with A = {1..9}, B = {9..1}, row-major
  int c_exp [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

  mips_main dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .d11(d11), .d12(d12), .d13(d13),
    .d21(d21), .d22(d22), .d23(d23),
    .d31(d31), .d32(d32), .d33(d33)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic logic [31:0] get_d(int i);
    case (i)
      0: return d11; 1: return d12; 2: return d13;
      3: return d21; 4: return d22; 5: return d23;
      6: return d31; 7: return d32; default: return d33;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string pfx, input bit zero);
    for (int i = 0; i < 9; i++)
      check_eq($sformatf("%s_d%0d%0d", pfx, i / 3 + 1, i % 3 + 1), get_d(i),
               zero ? 32'd0 : 32'(c_exp[i]));
  endtask

  // Executes pc = from, from+4, ... up to and including upto, one per edge.
  task automatic run_pc(input logic [31:0] from, input logic [31:0] upto);
    logic [31:0] p;
    p = from;
    forever begin
      pc = p;
      tick();
      if (p == upto) break;
      p = p + 32'd4;
    end
  endtask

  initial begin
    // reset held with clocks running
    rst_n = 1'b0;
    pc = 32'hFFFF_FFFC;
    repeat (4) tick();
    check_all("reset", 1'b1);

    // full program: 250 edges starting at pc = -4
    rst_n = 1'b1;
    run_pc(32'hFFFF_FFFC, 32'hFFFF_FFFC + 32'd4 * 32'd249);
    tick();
    check_all("run", 1'b0);

    // out-of-ROM hold leaves results alone
    pc = 32'h0000_1000;
    repeat (20) tick();
    check_all("hold", 1'b0);

    // reset mid-run clears outputs without waiting for a clock
    run_pc(32'hFFFF_FFFC, 32'h0000_0100);
    rst_n = 1'b0;
    #1;
    check_all("midrst", 1'b1);
    tick();
    rst_n = 1'b1;
    run_pc(32'hFFFF_FFFC, 32'h0000_03E0);
    tick();
    check_all("rerun", 1'b0);

    // hold on the instruction before the first sw, then on the first sw (word 23)
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    run_pc(32'hFFFF_FFFC, 32'h0000_0058);
    repeat (4) tick();
    check_eq("pre_sw_d11", d11, 32'd0);
    pc = 32'h0000_005C;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("sw_hold%0d_d11", i), d11, 32'd30);
      tick();
    end
    check_eq("sw_hold_d12", d12, 32'd0);
    check_eq("sw_hold_d33", d33, 32'd0);

    // finish the program, then force single instructions
    run_pc(32'h0000_0060, 32'h0000_011C);
    pc = 32'h0000_1000;
    tick();
    check_eq("pre_force_d11", d11, 32'd30);
    force dut.instr = {6'h08, 5'd0, 5'd0, 16'd5};     // addi $0,$0,5
    tick();
    force dut.instr = {6'h2B, 5'd0, 5'd0, 16'd72};    // sw $0,72($0)
    tick();
    force dut.instr = {6'h2B, 5'd0, 5'd1, 16'd76};    // sw $1,76($0)
    tick();
    release dut.instr;
    tick();
    tick();
    check_eq("force_zero_d11", d11, 32'd0);
    check_eq("force_r1_d12", d12, 32'd1);
    check_eq("force_keep_d13", d13, 32'd18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
